// File: rtl/fp_pkg.sv
// Shared fp32/bf16 field widths, canonical NaNs and narrowing flags.
// Used by bf16_round_rne and bf16_narrow.
package fp_pkg;

   localparam int FP32_W     = 32;
   localparam int FP32_EXP_W = 8;
   localparam int FP32_MAN_W = 23;
   localparam int BF16_W     = 16;
   localparam int BF16_EXP_W = 8;
   localparam int BF16_MAN_W = 7;

   localparam logic [BF16_W-1:0] BF16_QNAN = 16'h7FFF;
   localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FFFFFFF;

   typedef struct packed {
      logic nan;
      logic overflow;
      logic flush;
      logic inexact;
   } narrow_flags_t;

endpackage

// File: rtl/bf16_round_rne.sv
// Combinational fp32 -> bf16 classify and round-to-nearest-even.
// Specials follow the multiplier: canonical NaN, denormals flushed.
module bf16_round_rne
   import fp_pkg::*;
(
   input  logic [FP32_W-1:0] i_data,
   output logic [BF16_W-1:0] o_data,
   output narrow_flags_t     o_flags
);

   logic                  w_sign;
   logic [FP32_EXP_W-1:0] w_exp;
   logic [FP32_MAN_W-1:0] w_man;
   logic                  w_man_nz;
   logic                  w_is_nan;
   logic                  w_is_inf;
   logic                  w_is_zero;
   logic                  w_is_den;
   logic                  w_lsb;
   logic                  w_guard;
   logic                  w_sticky;
   logic                  w_up;
   logic [BF16_W-1:0]     w_rnd;

   assign w_sign    = i_data[31];
   assign w_exp     = i_data[30:23];
   assign w_man     = i_data[22:0];
   assign w_man_nz  = |w_man;
   assign w_is_nan  = (w_exp == 8'hFF) && w_man_nz;
   assign w_is_inf  = (w_exp == 8'hFF) && !w_man_nz;
   assign w_is_zero = (w_exp == 8'h00) && !w_man_nz;
   assign w_is_den  = (w_exp == 8'h00) && w_man_nz;

   assign w_lsb    = i_data[16];
   assign w_guard  = i_data[15];
   assign w_sticky = |i_data[14:0];
   assign w_up     = w_guard & (w_sticky | w_lsb);

   // mantissa carry ripples into the exponent; exp<=254 keeps sign safe
   assign w_rnd = i_data[31:16] + {15'd0, w_up};

   // pick the result class; the four special classes are disjoint
   always_comb begin
      o_data  = w_rnd;
      o_flags = '0;
      unique case (1'b1)
         w_is_nan: begin
            o_data      = BF16_QNAN;
            o_flags.nan = 1'b1;
         end
         w_is_inf: begin
            o_data = {w_sign, 8'hFF, 7'h00};
         end
         w_is_zero: begin
            o_data = {w_sign, 15'h0000};
         end
         w_is_den: begin
            o_data        = {w_sign, 15'h0000};
            o_flags.flush = 1'b1;
         end
         default: begin
            o_flags.inexact  = w_guard | w_sticky;
            o_flags.overflow = (w_rnd[14:7] == 8'hFF);
         end
      endcase
   end

endmodule

// File: rtl/bf16_narrow.sv
// Two-stage elastic fp32 -> bf16 narrowing converter (valid/ready).
// Optional saturating flag counters: define BF16_NARROW_STATS_EN.
module bf16_narrow
   import fp_pkg::*;
`ifdef BF16_NARROW_STATS_EN
#(
   parameter int CNT_W = 16
)
`endif
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FP32_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BF16_W-1:0] out_data,
   output logic [3:0]        out_flags
`ifdef BF16_NARROW_STATS_EN
   ,
   input  logic              stats_clr,
   output logic [CNT_W-1:0]  nan_cnt,
   output logic [CNT_W-1:0]  ovf_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   logic [BF16_W-1:0] w_rnd_data;
   narrow_flags_t     w_rnd_flags;

   logic              r_s1_valid;
   logic [BF16_W-1:0] r_s1_data;
   narrow_flags_t     r_s1_flags;

   logic              r_out_valid;
   logic [BF16_W-1:0] r_out_data;
   narrow_flags_t     r_out_flags;

   logic              w_s2_load;
   logic              w_s1_adv;
   logic              w_in_ready;
   logic              w_out_fire;

   bf16_round_rne u_rne (
      .i_data  (in_data),
      .o_data  (w_rnd_data),
      .o_flags (w_rnd_flags)
   );

   assign w_s2_load  = !r_out_valid || out_ready;
   assign w_s1_adv   = r_s1_valid && w_s2_load;
   assign w_in_ready = rst_n && (!r_s1_valid || w_s1_adv);
   assign w_out_fire = r_out_valid && out_ready;

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_flags = r_out_flags;

   // S1: capture the rounded result whenever the stage can take a beat
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_s1_flags <= '0;
      end else if (w_in_ready) begin
         r_s1_valid <= in_valid;
         r_s1_data  <= w_rnd_data;
         r_s1_flags <= w_rnd_flags;
      end
   end

   // S2: output register, held stable under backpressure
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_flags <= '0;
      end else if (w_s2_load) begin
         r_out_valid <= r_s1_valid;
         r_out_data  <= r_s1_data;
         r_out_flags <= r_s1_flags;
      end
   end

`ifdef BF16_NARROW_STATS_EN
   logic [CNT_W-1:0] r_nan_cnt;
   logic [CNT_W-1:0] r_ovf_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // saturating per-flag counters; clear wins over a same-cycle increment
   always_ff @(posedge clk) begin
      if (!rst_n || stats_clr) begin
         r_nan_cnt   <= '0;
         r_ovf_cnt   <= '0;
         r_flush_cnt <= '0;
      end else if (w_out_fire) begin
         if (r_out_flags.nan && (r_nan_cnt != '1))
            r_nan_cnt <= r_nan_cnt + 1'b1;
         if (r_out_flags.overflow && (r_ovf_cnt != '1))
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
         if (r_out_flags.flush && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign nan_cnt   = r_nan_cnt;
   assign ovf_cnt   = r_ovf_cnt;
   assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_bf16_narrow.sv
// Self-checking bench for bf16_narrow: directed vectors, backpressure,
// mid-stream reset, random traffic; stats checks with BF16_NARROW_STATS_EN.
module tb_bf16_narrow;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  out_flags;
`ifdef BF16_NARROW_STATS_EN
   logic        stats_clr;
   logic [1:0]  nan_cnt;
   logic [1:0]  ovf_cnt;
   logic [1:0]  flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] pend_q[$];
   logic [19:0] pexp_q[$];
   logic [19:0] exp_q[$];

   int cyc_n  = 0;
   int n_in   = 0;
   int n_out  = 0;
   int t_in   = 0;
   int t_out  = 0;
   int t_first = 0;

`ifdef BF16_NARROW_STATS_EN
   bf16_narrow #(.CNT_W(2)) dut (
`else
   bf16_narrow dut (
`endif
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags)
`ifdef BF16_NARROW_STATS_EN
      ,
      .stats_clr (stats_clr),
      .nan_cnt   (nan_cnt),
      .ovf_cnt   (ovf_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // reference: {nan,ovf,flush,inexact, bf16} from plain arithmetic
   function automatic logic [19:0] ref_conv(input logic [31:0] x);
      int unsigned e, m, s, hi, lo, r;
      bit up;
      logic [15:0] res;
      logic [3:0]  fl;
      e = (x >> 23) & 32'hFF;
      m = x & 32'h7FFFFF;
      s = x >> 31;
      fl = 4'b0000;
      if (e == 255 && m != 0) begin
         res = 16'h7FFF;
         fl  = 4'b1000;
      end else if (e == 255) begin
         res = 16'(s * 32768 + 255 * 128);
      end else if (e == 0) begin
         res = 16'(s * 32768);
         if (m != 0) fl = 4'b0010;
      end else begin
         hi = x >> 16;
         lo = x & 32'hFFFF;
         up = (lo > 32768) || (lo == 32768 && (hi % 2) == 1);
         r  = hi + (up ? 1 : 0);
         res = 16'(r);
         fl[0] = (lo != 0);
         fl[2] = (((r >> 7) & 255) == 255);
      end
      return {fl, res};
   endfunction

   function automatic logic [31:0] rnd_word();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 5))
         0: w[30:23] = 8'h00;
         1: w[30:23] = 8'hFF;
         2: begin
            w[30:23] = 8'hFE;
            w[22:16] = 7'h7F;
         end
         3: w[15:0] = 16'h8000;
         4: w[22:0] = '0;
         default: ;
      endcase
      return w;
   endfunction

   task automatic push_ref(input logic [31:0] w);
      pend_q.push_back(w);
      pexp_q.push_back(ref_conv(w));
   endtask

   task automatic push_dir(input logic [31:0] w, input logic [15:0] d,
                           input logic [3:0] f);
      pend_q.push_back(w);
      pexp_q.push_back({f, d});
   endtask

   // one clock: drive, sample mid-cycle, score transfers, advance
   task automatic cyc(input bit ven, input bit rdy);
      logic [19:0] e;
      bit fin;
      bit fout;
      in_valid  = ven && (pend_q.size() > 0);
      in_data   = in_valid ? pend_q[0] : $urandom;
      out_ready = rdy;
      #1;
      fin  = in_valid && in_ready;
      fout = out_valid && out_ready;
      if (fout) begin
         if (exp_q.size() == 0) begin
            chk("extra_beat", 32'(out_data), 32'hFFFFFFFF);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", 32'(out_data), 32'(e[15:0]));
            chk("out_flags", 32'(out_flags), 32'(e[19:16]));
         end
         if (n_out == 0) t_first = cyc_n;
         n_out++;
         t_out = cyc_n;
      end
      if (fin) begin
         exp_q.push_back(pexp_q.pop_front());
         void'(pend_q.pop_front());
         n_in++;
         t_in = cyc_n;
      end
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((pend_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
         cyc(1'b1, 1'b1);
         n++;
      end
      chk("drain_left", 32'(pend_q.size() + exp_q.size()), 32'd0);
   endtask

   logic [15:0] held;
   logic [3:0]  heldf;
   bit          have_held;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
`ifdef BF16_NARROW_STATS_EN
      stats_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_flags", 32'(out_flags), 32'd0);
`ifdef BF16_NARROW_STATS_EN
      chk("rst_nan_cnt", 32'(nan_cnt), 32'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // latency of a lone beat
      push_dir(32'h3F800000, 16'h3F80, 4'b0000);
      n_out = 0;
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1);
      chk("lat_count", 32'(n_out), 32'd1);
      chk("latency", 32'(t_out - t_in), 32'd2);

      // directed vectors back to back
      push_dir(32'h3F808000, 16'h3F80, 4'b0001);
      push_dir(32'h3F818000, 16'h3F82, 4'b0001);
      push_dir(32'h7F7FFFFF, 16'h7F80, 4'b0101);
      push_dir(32'hFF800000, 16'hFF80, 4'b0000);
      push_dir(32'hFFC00001, 16'h7FFF, 4'b1000);
      push_dir(32'h80000000, 16'h8000, 4'b0000);
      push_dir(32'h00400000, 16'h0000, 4'b0010);
      drain(40);

      // backpressure: 6 stalled cycles, 5 beats offered
      for (int i = 0; i < 5; i++) push_ref(rnd_word());
      n_in = 0;
      have_held = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b0);
         if (out_valid) begin
            if (have_held) begin
               chk("bp_hold_data", 32'(out_data), 32'(held));
               chk("bp_hold_flags", 32'(out_flags), 32'(heldf));
            end
            held      = out_data;
            heldf     = out_flags;
            have_held = 1'b1;
         end
      end
      chk("bp_accepted", 32'(n_in), 32'd2);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      n_out = 0;
      for (int i = 0; i < 20 && n_out < 5; i++) cyc(1'b1, 1'b1);
      chk("bp_released", 32'(n_out), 32'd5);
      chk("bp_no_gap", 32'(t_out - t_first), 32'd4);
      drain(10);

      // mid-stream reset with two beats in flight
      push_ref(rnd_word());
      push_ref(rnd_word());
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("mrst_out_valid", 32'(out_valid), 32'd0);
      exp_q.delete();
      pend_q.delete();
      pexp_q.delete();
      n_out = 0;
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
      chk("mrst_stale", 32'(n_out), 32'd0);

      // random traffic against the reference model
      for (int i = 0; i < 300; i++) push_ref(rnd_word());
      for (int i = 0; i < 3000; i++) begin
         if (pend_q.size() == 0 && exp_q.size() == 0) break;
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end
      drain(50);

`ifdef BF16_NARROW_STATS_EN
      stats_clr = 1'b1;
      @(posedge clk);
      #1;
      stats_clr = 1'b0;
      for (int i = 0; i < 5; i++) push_ref(32'h7FC00000);
      drain(30);
      chk("nan_sat", 32'(nan_cnt), 32'd3);
      stats_clr = 1'b1;
      push_ref(32'hFF800001);
      drain(10);
      @(posedge clk);
      #1;
      stats_clr = 1'b0;
      chk("nan_clr", 32'(nan_cnt), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1);
   end

endmodule
